// File: rtl/subtractor_serial.sv
// Bit-serial ripple subtractor: computes a - b - bin one bit per clock, LSB
// first, and hands back the WIDTH-bit difference together with the borrow-out.
// Operands are captured only when the block accepts them. diff/bout come from
// dedicated output registers, so they hold their last value while a new
// operation is being computed.
module subtractor_serial #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // The bit counter must reach WIDTH-1; keep at least one bit so WIDTH=1 is legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_diff;
    logic             br_next;
    logic [WIDTH-1:0] d_shift;

    // One full-subtractor slice working on the current LSBs of the shift registers.
    assign bit_diff = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    // The new difference bit enters at the MSB; after WIDTH shifts D holds the result LSB-aligned.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign d_shift = bit_diff;
        end else begin : g_shift_wn
            assign d_shift = {bit_diff, d_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and handshake outputs; every register defaults to holding.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                br_d  = br_next;
                d_d   = d_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the finished result into the output registers.
                    diff_d  = d_shift;
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight and clears all datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: three instances (WIDTH 1, 3 and 8) checked every
// cycle against an arithmetic model of the handshake timing and the result.
module tb_subtractor_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0 -> WIDTH 1, index 1 -> WIDTH 3, index 2 -> WIDTH 8.
    logic        in_valid_t [3];
    logic        out_ready_t[3];
    logic [31:0] a_t        [3];
    logic [31:0] b_t        [3];
    logic        bin_t      [3];
    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic        bout_w     [3];
    logic [31:0] diff_w     [3];

    logic [0:0] diff1;
    logic [2:0] diff3;
    logic [7:0] diff8;
    assign diff_w[0] = 32'(diff1);
    assign diff_w[1] = 32'(diff3);
    assign diff_w[2] = 32'(diff8);

    subtractor_serial #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t[0]), .in_ready(in_ready_w[0]),
        .a(a_t[0][0:0]), .b(b_t[0][0:0]), .bin(bin_t[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_t[0]),
        .diff(diff1), .bout(bout_w[0])
    );
    subtractor_serial #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t[1]), .in_ready(in_ready_w[1]),
        .a(a_t[1][2:0]), .b(b_t[1][2:0]), .bin(bin_t[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_t[1]),
        .diff(diff3), .bout(bout_w[1])
    );
    subtractor_serial #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t[2]), .in_ready(in_ready_w[2]),
        .a(a_t[2][7:0]), .b(b_t[2][7:0]), .bin(bin_t[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_t[2]),
        .diff(diff8), .bout(bout_w[2])
    );

    function automatic int wid(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 8;
        endcase
    endfunction

    function automatic longint msk(input int w);
        return (longint'(1) <<< w) - 1;
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int w, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (WIDTH=%0d) at %0t: got %0h, want %0h", name, w, $time, act, exp);
        end
    endfunction

    // Hand-computed expectation attached to the next WIDTH-3 accept.
    bit          lit_en = 1'b0;
    logic [31:0] lit_d  = '0;
    logic        lit_b  = 1'b0;
    event        chk_ev;

    // Model: 0 = idle, 1 = computing, 2 = presenting a result.
    int     phase[3] = '{0, 0, 0};
    int     cnt  [3] = '{0, 0, 0};
    longint ea   [3];
    longint eb   [3];
    longint ebin [3];
    longint ed   [3];
    longint ebo  [3];
    bit     pl = 1'b0;
    longint pld, plb;

    // Single compare process: checks outputs against the model, then advances it.
    always @(negedge clk or chk_ev) begin
        for (int i = 0; i < 3; i++) begin
            int w;
            longint full;
            w = wid(i);
            if (!rst_n) begin
                chk("rst_in_ready", w, longint'(in_ready_w[i]), 1);
                chk("rst_out_valid", w, longint'(out_valid_w[i]), 0);
                chk("rst_diff", w, longint'(diff_w[i]), 0);
                chk("rst_bout", w, longint'(bout_w[i]), 0);
                phase[i] = 0;
                if (i == 1) pl = 1'b0;
            end else if (clk == 1'b0) begin
                case (phase[i])
                    0: begin
                        chk("idle_in_ready", w, longint'(in_ready_w[i]), 1);
                        chk("idle_out_valid", w, longint'(out_valid_w[i]), 0);
                        if (in_valid_t[i]) begin
                            ea[i]   = longint'(a_t[i]) & msk(w);
                            eb[i]   = longint'(b_t[i]) & msk(w);
                            ebin[i] = longint'(bin_t[i]);
                            full    = ea[i] - eb[i] - ebin[i];
                            ebo[i]  = (full < 0) ? 1 : 0;
                            ed[i]   = full & msk(w);
                            phase[i] = 1;
                            cnt[i]   = 0;
                            if (i == 1) begin
                                pl  = lit_en;
                                pld = longint'(lit_d);
                                plb = longint'(lit_b);
                            end
                        end
                    end
                    1: begin
                        chk("busy_in_ready", w, longint'(in_ready_w[i]), 0);
                        chk("busy_out_valid", w, longint'(out_valid_w[i]), 0);
                        cnt[i]++;
                        if (cnt[i] == w) phase[i] = 2;
                    end
                    default: begin
                        chk("done_out_valid", w, longint'(out_valid_w[i]), 1);
                        chk("done_in_ready", w, longint'(in_ready_w[i]), 0);
                        chk("diff", w, longint'(diff_w[i]), ed[i]);
                        chk("bout", w, longint'(bout_w[i]), ebo[i]);
                        chk("identity", w,
                            longint'(diff_w[i]) + eb[i] + ebin[i],
                            ea[i] + (longint'(bout_w[i]) <<< w));
                        if (i == 1 && pl) begin
                            chk("literal_diff", w, longint'(diff_w[i]), pld);
                            chk("literal_bout", w, longint'(bout_w[i]), plb);
                        end
                        if (out_ready_t[i]) begin
                            phase[i] = 0;
                            if (i == 1) pl = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH-3 operation with a hand-computed expectation, optional
    // backpressure and optional input toggling while the block is busy.
    task automatic op3(input logic [2:0] av, input logic [2:0] bv, input logic bi,
                       input logic [2:0] dexp, input logic bexp,
                       input int hold, input bit toggle);
        a_t[1]         = 32'(av);
        b_t[1]         = 32'(bv);
        bin_t[1]       = bi;
        in_valid_t[1]  = 1'b1;
        out_ready_t[1] = (hold == 0);
        lit_en         = 1'b1;
        lit_d          = 32'(dexp);
        lit_b          = bexp;
        tick();
        in_valid_t[1] = 1'b0;
        lit_en        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (toggle) begin
                a_t[1]        = ~a_t[1] & 32'h7;
                b_t[1]        = ~b_t[1] & 32'h7;
                bin_t[1]      = ~bin_t[1];
                in_valid_t[1] = ~in_valid_t[1];
            end
            tick();
        end
        in_valid_t[1] = 1'b0;
        repeat (hold) tick();
        out_ready_t[1] = 1'b1;
        tick();
        tick();
        $display("op W=3 a=%0d b=%0d bin=%0d expect diff=%0d bout=%0d hold=%0d toggle=%0d",
                 av, bv, bi, dexp, bexp, hold, toggle);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_t[i]  = 1'b0;
            out_ready_t[i] = 1'b1;
            a_t[i]         = '0;
            b_t[i]         = '0;
            bin_t[i]       = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        op3(3'd5, 3'd3, 1'b0, 3'd2, 1'b0, 0, 1'b0);
        op3(3'd3, 3'd5, 1'b0, 3'd6, 1'b1, 0, 1'b0);
        op3(3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 0, 1'b0);
        op3(3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 0, 1'b0);
        op3(3'd4, 3'd3, 1'b1, 3'd0, 1'b0, 5, 1'b0);
        op3(3'd6, 3'd1, 1'b0, 3'd5, 1'b0, 0, 1'b1);

        // Abort an operation in its second RUN cycle; the result must never appear.
        a_t[1]        = 32'd7;
        b_t[1]        = 32'd2;
        bin_t[1]      = 1'b0;
        in_valid_t[1] = 1'b1;
        tick();
        in_valid_t[1] = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 -> chk_ev;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("op W=3 reset during RUN, operation aborted");
        op3(3'd2, 3'd1, 1'b0, 3'd1, 1'b0, 0, 1'b0);

        // Random back-to-back traffic on all widths with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid_t[i]  = ($urandom_range(3) != 0);
                a_t[i]         = $urandom & 32'(msk(wid(i)));
                b_t[i]         = $urandom & 32'(msk(wid(i)));
                bin_t[i]       = 1'($urandom_range(1));
                out_ready_t[i] = ($urandom_range(2) != 0);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            in_valid_t[i]  = 1'b0;
            out_ready_t[i] = 1'b1;
        end
        repeat (12) tick();
        $display("random phase: 3000 cycles on WIDTH 1, 3 and 8");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
